do_tan_so: RTL and testbench

- Frequency meter: counts rising edges of an asynchronous pulse input over a fixed gate window of reference clocks. Reports the count once per window.
- This is the measuring end of the team's pulse-divider outputs. It verifies divided clocks (e.g. 1 Hz from 100 MHz) on-board and feeds display/UART logic.
- Runs back-to-back windows continuously while enabled.

---
 rtl/do_tan_so.sv | 119 +++++++++++
 tb/tb_do_tan_so.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/do_tan_so.sv
// Frequency meter: counts synchronized rising edges of sig_in over GATE_CYCLES clki cycles.
// One result per window (valid pulse); windows run back to back while en is held.
module do_tan_so #(
   parameter int GATE_CYCLES = 100000000,
   parameter int CNT_W       = 32
) (
   input  logic             clki,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq,
   output logic             valid,
   output logic             ovf,
   output logic             busy
);

   localparam int GW = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t           state_q, state_d;
   logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [CNT_W-1:0] freq_q, freq_d;
   logic             sat_q, sat_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic             rise;

   assign rise = s2_q & ~s3_q;

   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
      sat_d      = sat_q;
      freq_d     = freq_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;
      s1_d       = sig_in;
      s2_d       = s1_q;
      s3_d       = s2_q;

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d    = MEASURE;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
               sat_d      = 1'b0;
            end
         end
         MEASURE: begin
            if (gate_cnt_q == GATE_LAST) begin
               // A rise on the last gate cycle still belongs to the closing window.
               if (rise && (edge_cnt_q == CNT_MAX)) begin
                  freq_d = CNT_MAX;
                  ovf_d  = 1'b1;
               end else begin
                  freq_d = edge_cnt_q + CNT_W'(rise);
                  ovf_d  = sat_q;
               end
               valid_d    = 1'b1;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
               sat_d      = 1'b0;
               if (!en) state_d = IDLE;
            end else if (!en) begin
               state_d    = IDLE;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
               sat_d      = 1'b0;
            end else begin
               gate_cnt_d = gate_cnt_q + GW'(1);
               if (rise) begin
                  if (edge_cnt_q == CNT_MAX) sat_d = 1'b1;
                  else                       edge_cnt_d = edge_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clki) begin
      if (rst) begin
         state_q    <= IDLE;
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         sat_q      <= 1'b0;
         freq_q     <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         sat_q      <= sat_d;
         freq_q     <= freq_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
      end
   end

   assign freq  = freq_q;
   assign valid = valid_q;
   assign ovf   = ovf_q;
   assign busy  = (state_q == MEASURE);

endmodule

// File: tb/tb_do_tan_so.sv
// Bench for do_tan_so: a wide-counter and a 3-bit-counter instance share stimulus and
// are compared every cycle against a window/edge-counting reference model.
module tb_do_tan_so;

   localparam int G    = 100;
   localparam int NSMP = 16384;

   logic        clki = 1'b0;
   logic        rst = 1'b1, en = 1'b0, sig_in = 1'b0;
   logic [31:0] freq_w;
   logic        valid_w, ovf_w, busy_w;
   logic [2:0]  freq_s;
   logic        valid_s, ovf_s, busy_s;

   always #5 clki = ~clki;

   do_tan_so #(.GATE_CYCLES(G), .CNT_W(32)) dut_w (
      .clki(clki), .rst(rst), .en(en), .sig_in(sig_in),
      .freq(freq_w), .valid(valid_w), .ovf(ovf_w), .busy(busy_w));

   do_tan_so #(.GATE_CYCLES(G), .CNT_W(3)) dut_s (
      .clki(clki), .rst(rst), .en(en), .sig_in(sig_in),
      .freq(freq_s), .valid(valid_s), .ovf(ovf_s), .busy(busy_s));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: remembers what the synchronizer sampled on every edge and,
   // at each window end, counts 0->1 transitions of that sampled stream over the window.
   bit          smp[NSMP];
   int          m_edge = 2;
   bit          m_meas = 1'b0;
   int          m_ws   = 0;
   int          n;
   bit          chk_on = 1'b0;
   bit          e_valid = 1'b0, e_ovf_w = 1'b0, e_ovf_s = 1'b0;
   logic [31:0] e_freq_w = '0;
   logic [2:0]  e_freq_s = '0;

   always @(posedge clki) begin
      m_edge++;
      if (m_edge >= NSMP) begin
         $display("FAIL model_overrun got=%0d exp=%0d", m_edge, NSMP - 1);
         $fatal(1, "model history exhausted");
      end
      smp[m_edge] = rst ? 1'b0 : sig_in;
      e_valid = 1'b0;
      if (rst) begin
         m_meas = 1'b0;
         e_freq_w = '0; e_ovf_w = 1'b0;
         e_freq_s = '0; e_ovf_s = 1'b0;
         chk_on = 1'b1;
      end else if (!m_meas) begin
         if (en) begin
            m_meas = 1'b1;
            m_ws   = m_edge + 1;
         end
      end else if (m_edge == m_ws + G - 1) begin
         n = 0;
         for (int k = m_ws; k <= m_edge; k++)
            if (smp[k-2] && !smp[k-3]) n++;
         e_freq_w = n;
         e_ovf_w  = 1'b0;
         e_freq_s = (n > 7) ? 3'd7 : n[2:0];
         e_ovf_s  = (n > 7);
         e_valid  = 1'b1;
         if (en) m_ws = m_edge + 1;
         else    m_meas = 1'b0;
      end else if (!en) begin
         m_meas = 1'b0;
      end
   end

   always @(negedge clki) begin
      if (chk_on) begin
         chk("valid_w", valid_w, e_valid);
         chk("busy_w",  busy_w,  m_meas);
         chk("freq_w",  freq_w,  e_freq_w);
         chk("ovf_w",   ovf_w,   e_ovf_w);
         chk("valid_s", valid_s, e_valid);
         chk("busy_s",  busy_s,  m_meas);
         chk("freq_s",  freq_s,  e_freq_s);
         chk("ovf_s",   ovf_s,   e_ovf_s);
      end
   end

   // sig_in generator: 0 = hold, 1 = fixed hi/lo phases, 2 = random phases of 2..12 cycles
   int mode = 0;
   bit hold_val = 1'b0;
   int hi_len = 5, lo_len = 5;

   initial begin
      int  left;
      bit  lvl;
      left = 0;
      lvl  = 1'b0;
      forever begin
         @(negedge clki);
         #1;
         if (mode == 0) begin
            lvl  = hold_val;
            left = 0;
         end else begin
            if (left == 0) begin
               lvl  = ~lvl;
               left = (mode == 1) ? (lvl ? hi_len : lo_len) : int'($urandom_range(2, 12));
            end
            left--;
         end
         sig_in = lvl;
      end
   end

   task automatic wait_valid();
      for (int i = 0; i < 300; i++) begin
         @(negedge clki);
         if (valid_w === 1'b1) return;
      end
      chk("wait_valid_timeout", 0, 1);
   endtask

   // Returns at the negedge just before the edge at window position p.
   task automatic wait_pos(input int p);
      for (int i = 0; i < 300; i++) begin
         @(negedge clki);
         if (m_meas && (m_edge + 1 - m_ws == p)) return;
      end
      chk("wait_pos_timeout", 0, 1);
   endtask

   task automatic start_and_time(input string tag);
      int k;
      en = 1'b1;
      k  = 0;
      do begin
         @(negedge clki);
         k++;
      end while (valid_w !== 1'b1 && k < 400);
      chk(tag, k, G + 1);
   endtask

   initial begin
      int gap;
      mode = 1; hi_len = 2; lo_len = 2;
      rst = 1'b1; en = 1'b0;
      repeat (3) @(negedge clki);
      rst = 1'b0;
      repeat (20) @(negedge clki);
      chk("idle_busy", busy_w, 0);
      chk("idle_freq", freq_w, 0);

      // basic count, period 10
      hi_len = 5; lo_len = 5;
      start_and_time("first_valid_latency");
      gap = 0;
      do begin
         @(negedge clki);
         gap++;
      end while (valid_w !== 1'b1 && gap < 400);
      chk("valid_period", gap, G);
      repeat (150) @(negedge clki);
      chk("basic_freq", freq_w, 10);
      chk("basic_ovf", ovf_w, 0);
      chk("basic_sat_freq", freq_s, 7);
      chk("basic_sat_ovf", ovf_s, 1);

      // single slow edge, then an empty window
      mode = 0; hold_val = 1'b0;
      wait_valid();
      wait_valid();
      wait_pos(50);
      hold_val = 1'b1;
      repeat (5) @(negedge clki);
      hold_val = 1'b0;
      wait_valid();
      chk("single_edge", freq_w, 1);
      wait_valid();
      chk("empty_window", freq_w, 0);

      // rise landing on the window-end cycle
      wait_pos(97);
      hold_val = 1'b1;
      wait_valid();
      chk("boundary_end", freq_w, 1);
      wait_valid();
      chk("boundary_next", freq_w, 0);

      // abort mid-window, then restart
      mode = 1; hi_len = 5; lo_len = 5;
      wait_valid();
      wait_valid();
      wait_pos(40);
      en = 1'b0;
      repeat (10) @(negedge clki);
      chk("abort_busy", busy_w, 0);
      chk("abort_freq_hold", freq_w, 10);
      start_and_time("restart_latency");

      // saturation of the narrow counter, then reset mid-window
      hi_len = 2; lo_len = 2;
      wait_valid();
      wait_valid();
      chk("sat_wide_freq", freq_w, 25);
      chk("sat_freq", freq_s, 7);
      chk("sat_ovf", ovf_s, 1);
      wait_pos(30);
      rst = 1'b1;
      @(negedge clki);
      rst = 1'b0; en = 1'b0;
      chk("rst_freq_s", freq_s, 0);
      chk("rst_ovf_s", ovf_s, 0);
      chk("rst_busy", busy_w, 0);
      repeat (5) @(negedge clki);

      // randomized traffic
      mode = 2; en = 1'b1;
      repeat (1500) begin
         @(negedge clki);
         if ($urandom_range(0, 199) == 0) en = ~en;
         rst = ($urandom_range(0, 999) == 0);
      end
      rst = 1'b0;
      repeat (5) @(negedge clki);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=%0t exp=finish", $time);
      $fatal(1, "timeout");
   end

endmodule
